add_arbiter: RTL

Round-robin arbiter and two-stage pipeline that shares one 32-bit `cla` adder instance among `NREQ` requesters. Each requester offers an operand pair over a valid/ready handshake. The block grants one requester per cycle, registers the operands, and drives them through the shared adder. The 33-bit sum is returned on a single response port, tagged with the requester index and subject to backpressure. It sits between the client units and the carry-lookahead adder, so the adder never has more than one owner.

---
 rtl/add_arbiter_if.sv | 26 ++
 rtl/add_arbiter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/add_arbiter_if.sv
// Requester and response bundle for add_arbiter; the slave modport is the arbiter side.
// Handshake: a beat transfers on a rising edge where valid && ready; the source holds payload until then.
interface add_arbiter_if #(
    parameter int NREQ = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*32-1:0] req_a;
    logic [NREQ*32-1:0] req_b;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [32:0]        rsp_sum;
    logic [IDW-1:0]     rsp_id;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_id
    );
endinterface

// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one 32-bit carry-lookahead adder between NREQ requesters,
// with an operand register stage and a result register stage.
module cla (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [32:0] z
);
    logic [31:0] g;
    logic [31:0] p;
    logic [7:0]  grp_g;
    logic [7:0]  grp_p;
    logic [32:0] carry;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        grp_g = '0;
        grp_p = '0;
        for (int gi = 0; gi < 8; gi++) begin
            grp_g[gi] = g[gi*4+3]
                      | (p[gi*4+3] & g[gi*4+2])
                      | (p[gi*4+3] & p[gi*4+2] & g[gi*4+1])
                      | (p[gi*4+3] & p[gi*4+2] & p[gi*4+1] & g[gi*4]);
            grp_p[gi] = &p[gi*4 +: 4];
        end
    end

    // Full lookahead inside each 4-bit group; group carries chain on grp_g/grp_p.
    always_comb begin : carry_net
        logic cg;
        carry = '0;
        cg    = 1'b0;
        for (int gi = 0; gi < 8; gi++) begin
            carry[gi*4]   = cg;
            carry[gi*4+1] = g[gi*4] | (p[gi*4] & cg);
            carry[gi*4+2] = g[gi*4+1] | (p[gi*4+1] & g[gi*4])
                          | (p[gi*4+1] & p[gi*4] & cg);
            carry[gi*4+3] = g[gi*4+2] | (p[gi*4+2] & g[gi*4+1])
                          | (p[gi*4+2] & p[gi*4+1] & g[gi*4])
                          | (p[gi*4+2] & p[gi*4+1] & p[gi*4] & cg);
            cg = grp_g[gi] | (grp_p[gi] & cg);
        end
        carry[32] = cg;
    end

    assign z = {carry[32], p ^ carry[31:0]};
endmodule

module add_arbiter #(
    parameter int NREQ = 4
) (
    input  logic         clk,
    input  logic         rst,
    add_arbiter_if.slave bus
);
    localparam int IDW = $clog2(NREQ);

    logic [IDW-1:0] ptr;
    logic           gnt_found;
    logic [IDW-1:0] gnt_id;
    int             cand;
    logic           adv0;
    logic           adv1;
    logic           accept;

    logic           s1_valid;
    logic [31:0]    s1_a;
    logic [31:0]    s1_b;
    logic [IDW-1:0] s1_id;
    logic [32:0]    z;

    // First valid requester at or after ptr, searching upward with wrap.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        cand      = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(ptr) + k) % NREQ;
            if (!gnt_found && bus.req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_id    = IDW'(cand);
            end
        end
    end

    assign adv1   = !bus.rsp_valid || bus.rsp_ready;
    assign adv0   = !s1_valid || adv1;
    assign accept = gnt_found && adv0 && !rst;

    always_comb begin
        bus.req_ready = '0;
        if (accept) begin
            bus.req_ready[gnt_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= '0;
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_id    <= '0;
        end else begin
            if (accept) begin
                ptr <= IDW'((int'(gnt_id) + 1) % NREQ);
            end
            if (adv0) begin
                s1_valid <= accept;
                if (accept) begin
                    s1_a  <= bus.req_a[int'(gnt_id)*32 +: 32];
                    s1_b  <= bus.req_b[int'(gnt_id)*32 +: 32];
                    s1_id <= gnt_id;
                end
            end
        end
    end

    cla u_cla (
        .a (s1_a),
        .b (s1_b),
        .z (z)
    );

    // The adder output is registered directly; nothing else sits on this path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_sum   <= '0;
            bus.rsp_id    <= '0;
        end else if (adv1) begin
            bus.rsp_valid <= s1_valid;
            bus.rsp_sum   <= z;
            bus.rsp_id    <= s1_id;
        end
    end
endmodule
